// File: rtl/tlc_stream_controller.sv
// rtl/tlc_stream_controller.sv - lockstep greyscale/config stream sequencer for TLC5957-class drivers
// Registered outputs (lat, sin) are computed from the next state so they line up with the tick they belong to.
module tlc_stream_controller #(
   parameter int NB_DRIVERS    = 30,
   parameter int NB_MUX        = 8,
   parameter int WORDS_PER_MUX = 16,
   parameter int WORD_BITS     = 48,
   parameter int BLANKING_TIME = 72,
   parameter int GCLK_IDLE_MAX = 512,
   parameter logic [WORD_BITS-1:0] DEFAULT_CONF = '0,
   localparam int MUX_W = (NB_MUX > 1) ? $clog2(NB_MUX) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clk_enable,
   input  logic                             position_sync,
   input  logic                             conf_load,
   input  logic [WORD_BITS-1:0]             conf_data,
   input  logic                             data_valid,
   input  logic [NB_DRIVERS*WORD_BITS-1:0]  data_in,
   output logic                             data_ready,
   output logic                             driver_sclk,
   output logic                             driver_gclk,
   output logic                             driver_lat,
   output logic [NB_DRIVERS-1:0]            drivers_sin,
   output logic [MUX_W-1:0]                 mux_sel,
   output logic                             column_ready,
   output logic                             slice_done,
   output logic                             underrun,
   output logic                             sync_overrun
);

   localparam int M1     = (WORD_BITS + 1 > BLANKING_TIME) ? WORD_BITS + 1 : BLANKING_TIME;
   localparam int M2     = (M1 > GCLK_IDLE_MAX) ? M1 : GCLK_IDLE_MAX;
   localparam int M3     = (M2 > 15) ? M2 : 15;
   localparam int CNT_W  = $clog2(M3 + 1);
   localparam int WORD_W = (WORDS_PER_MUX > 1) ? $clog2(WORDS_PER_MUX) : 1;

   localparam logic [CNT_W-1:0]  FC_LAST   = CNT_W'(14);
   localparam logic [CNT_W-1:0]  CS_LAST   = CNT_W'(WORD_BITS);
   localparam logic [CNT_W-1:0]  CS_LAT    = CNT_W'(WORD_BITS - 4);
   localparam logic [CNT_W-1:0]  WF_LAST   = CNT_W'(4);
   localparam logic [CNT_W-1:0]  BL_LAST   = CNT_W'(BLANKING_TIME - 1);
   localparam logic [CNT_W-1:0]  SH_LAST   = CNT_W'(WORD_BITS - 1);
   localparam logic [CNT_W-1:0]  SH_LATGS  = CNT_W'(WORD_BITS - 3);
   localparam logic [CNT_W-1:0]  GIM       = CNT_W'(GCLK_IDLE_MAX);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_MUX - 1);
   localparam logic [MUX_W-1:0]  ROW_LAST  = MUX_W'(NB_MUX - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FCWRTEN, ST_CONF_SHIFT, ST_WRTFC_WAIT,
      ST_WAIT_SLICE, ST_BLANKING, ST_PAUSE, ST_SHIFT
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [WORD_W-1:0]   word_cnt, word_n;
   logic [MUX_W-1:0]    row, row_n;
   logic [WORD_BITS-1:0] shadow, conf_sh;
   logic                pending;
   logic [WORD_BITS-1:0] word_sh [NB_DRIVERS];

   logic pend_eff, shift_end, last_word, last_row, lat_n;

   assign pend_eff  = pending | conf_load;
   assign last_word = (word_cnt == WORD_LAST);
   assign last_row  = (row == ROW_LAST);
   assign shift_end = (state == ST_SHIFT) && (cnt == SH_LAST);

   assign driver_sclk = clk_enable & ((state == ST_FCWRTEN) ||
                                      (state == ST_CONF_SHIFT && cnt != '0) ||
                                      (state == ST_SHIFT));
   assign driver_gclk = clk_enable & ((state == ST_WAIT_SLICE && cnt < GIM) ||
                                      (state == ST_BLANKING && cnt != '0) ||
                                      (state == ST_PAUSE) || (state == ST_SHIFT));
   assign data_ready  = clk_enable & (state == ST_PAUSE) & data_valid;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      word_n  = word_cnt;
      row_n   = row;
      case (state)
         ST_IDLE: begin
            state_n = pend_eff ? ST_FCWRTEN : ST_WAIT_SLICE;
            cnt_n   = '0;
         end
         ST_FCWRTEN: begin
            if (cnt == FC_LAST) begin state_n = ST_CONF_SHIFT; cnt_n = '0; end
            else cnt_n = cnt + 1'b1;
         end
         ST_CONF_SHIFT: begin
            if (cnt == CS_LAST) begin state_n = ST_WRTFC_WAIT; cnt_n = '0; end
            else cnt_n = cnt + 1'b1;
         end
         ST_WRTFC_WAIT: begin
            if (cnt == WF_LAST) begin state_n = ST_WAIT_SLICE; cnt_n = '0; end
            else cnt_n = cnt + 1'b1;
         end
         ST_WAIT_SLICE: begin
            if (position_sync) begin
               cnt_n = '0;
               if (pend_eff) state_n = ST_FCWRTEN;
               else begin state_n = ST_BLANKING; row_n = '0; end
            end else if (cnt < GIM) begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_BLANKING: begin
            if (cnt == BL_LAST) begin state_n = ST_PAUSE; cnt_n = '0; end
            else cnt_n = cnt + 1'b1;
         end
         ST_PAUSE: begin
            if (data_valid) begin state_n = ST_SHIFT; cnt_n = '0; end
         end
         ST_SHIFT: begin
            if (cnt == SH_LAST) begin
               cnt_n = '0;
               if (!last_word) begin
                  word_n  = word_cnt + 1'b1;
                  state_n = ST_PAUSE;
               end else begin
                  word_n = '0;
                  if (last_row) begin row_n = '0; state_n = ST_WAIT_SLICE; end
                  else begin row_n = row + 1'b1; state_n = ST_BLANKING; end
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Single-pulse WRTGS, or 3-tick LATGS on the last word of a row
   assign lat_n = (state_n == ST_FCWRTEN) ||
                  (state_n == ST_CONF_SHIFT && cnt_n >= CS_LAT) ||
                  (state_n == ST_SHIFT && ((word_n == WORD_LAST) ? (cnt_n >= SH_LATGS)
                                                                 : (cnt_n == SH_LAST)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         word_cnt     <= '0;
         row          <= '0;
         shadow       <= DEFAULT_CONF;
         conf_sh      <= '0;
         pending      <= 1'b1;
         driver_lat   <= 1'b0;
         drivers_sin  <= '0;
         mux_sel      <= '0;
         column_ready <= 1'b0;
         slice_done   <= 1'b0;
         underrun     <= 1'b0;
         sync_overrun <= 1'b0;
         for (int i = 0; i < NB_DRIVERS; i++) word_sh[i] <= '0;
      end else if (clk_enable) begin
         state        <= state_n;
         cnt          <= cnt_n;
         word_cnt     <= word_n;
         row          <= row_n;
         driver_lat   <= lat_n;
         column_ready <= shift_end && last_word;
         slice_done   <= shift_end && last_word && last_row;
         if (state_n == ST_BLANKING && state != ST_BLANKING) mux_sel <= row_n;
         if (state == ST_PAUSE && !data_valid) underrun <= 1'b1;
         if (position_sync && state != ST_WAIT_SLICE) sync_overrun <= 1'b1;

         // The running config shift uses a private copy; a later load keeps pending set
         if (state == ST_FCWRTEN && state_n == ST_CONF_SHIFT) begin
            conf_sh <= shadow;
            pending <= 1'b0;
         end
         if (conf_load) begin
            shadow  <= conf_data;
            pending <= 1'b1;
         end

         drivers_sin <= '0;
         if (state_n == ST_CONF_SHIFT && cnt_n != '0) begin
            drivers_sin <= {NB_DRIVERS{conf_sh[WORD_BITS-1]}};
            conf_sh     <= conf_sh << 1;
         end else if (state == ST_PAUSE && state_n == ST_SHIFT) begin
            for (int i = 0; i < NB_DRIVERS; i++) begin
               drivers_sin[i] <= data_in[i*WORD_BITS + WORD_BITS - 1];
               word_sh[i]     <= data_in[i*WORD_BITS +: WORD_BITS] << 1;
            end
         end else if (state == ST_SHIFT && state_n == ST_SHIFT) begin
            for (int i = 0; i < NB_DRIVERS; i++) begin
               drivers_sin[i] <= word_sh[i][WORD_BITS-1];
               word_sh[i]     <= word_sh[i] << 1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tlc_stream_controller.sv
// tb/tb_tlc_stream_controller.sv - directed self-checking bench for tlc_stream_controller
module tb_tlc_stream_controller;

   localparam int NB   = 4;
   localparam int WB   = 48;
   localparam int MUXW = 3;
   localparam logic [WB-1:0] DCONF = 48'hA5C3_0F1E_9B27;
   localparam logic [WB-1:0] NCONF = 48'h1234_5678_9ABC;

   logic clk = 1'b0;
   logic rst, clk_enable, position_sync, conf_load, data_valid;
   logic [WB-1:0]    conf_data;
   logic [NB*WB-1:0] data_in;
   logic data_ready, driver_sclk, driver_gclk, driver_lat;
   logic [NB-1:0]    drivers_sin;
   logic [MUXW-1:0]  mux_sel;
   logic column_ready, slice_done, underrun, sync_overrun;

   int checks = 0;
   int failures = 0;

   int seq_lat_bad, seq_sclk_bad, seq_gclk_bad, seq_lane_bad;
   logic [WB-1:0] seq_word;
   int n_ready, n_col, n_done, done_at, n_sclk, n_wrtgs, n_latgs, lat_odd, mux_bad;
   int st_sclk, st_gclk, st_ready;
   logic ovr_before;
   logic [WB-1:0] w3 [NB];
   int gate_bad, first_ready, gate_sclk;

   tlc_stream_controller #(
      .NB_DRIVERS(NB), .NB_MUX(8), .WORDS_PER_MUX(16), .WORD_BITS(WB),
      .BLANKING_TIME(72), .GCLK_IDLE_MAX(512), .DEFAULT_CONF(DCONF)
   ) dut (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .position_sync(position_sync),
      .conf_load(conf_load), .conf_data(conf_data), .data_valid(data_valid),
      .data_in(data_in), .data_ready(data_ready), .driver_sclk(driver_sclk),
      .driver_gclk(driver_gclk), .driver_lat(driver_lat), .drivers_sin(drivers_sin),
      .mux_sel(mux_sel), .column_ready(column_ready), .slice_done(slice_done),
      .underrun(underrun), .sync_overrun(sync_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WB-1:0] pat(input int w, input int i);
      return {8'hA5, 8'(w), 8'(i), 8'h3C, 8'(w * 7 + i), 8'hC3};
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({data_ready, driver_sclk, driver_gclk, driver_lat, drivers_sin, mux_sel,
                  column_ready, slice_done, underrun, sync_overrun});
   endfunction

   // Config sequence; t=1 is the first FCWRTEN tick
   task automatic seq_run();
      logic e_lat, e_sclk, e_gclk;
      seq_lat_bad = 0; seq_sclk_bad = 0; seq_gclk_bad = 0; seq_lane_bad = 0; seq_word = '0;
      for (int t = 1; t <= 75; t++) begin
         cyc();
         position_sync = 1'b0;
         conf_load = 1'b0;
         #1;
         e_lat  = (t >= 1 && t <= 15) || (t >= 60 && t <= 64);
         e_sclk = (t >= 1 && t <= 15) || (t >= 17 && t <= 64);
         e_gclk = (t >= 70);
         if (driver_lat !== e_lat) seq_lat_bad++;
         if (driver_sclk !== e_sclk) seq_sclk_bad++;
         if (driver_gclk !== e_gclk) seq_gclk_bad++;
         if (t >= 17 && t <= 64) begin
            seq_word = {seq_word[WB-2:0], drivers_sin[0]};
            if (drivers_sin !== {NB{drivers_sin[0]}}) seq_lane_bad++;
         end else if (drivers_sin !== '0) begin
            seq_lane_bad++;
         end
      end
   endtask

   task automatic slice_run(input int len, input int stall_at, input int conf_at, input int sync_at);
      int wcount, capk, lat_run;
      wcount = 0; capk = 0; lat_run = 0;
      n_ready = 0; n_col = 0; n_done = 0; done_at = -1; n_sclk = 0; n_wrtgs = 0;
      n_latgs = 0; lat_odd = 0; mux_bad = 0; st_sclk = 0; st_gclk = 0; st_ready = 0;
      ovr_before = 1'bx;
      for (int i = 0; i < NB; i++) w3[i] = '0;
      cyc();
      position_sync = 1'b1;
      data_valid = 1'b1;
      #1;
      for (int s = 0; s <= len; s++) begin
         cyc();
         position_sync = (s == sync_at);
         conf_load = (s == conf_at);
         data_valid = !(s >= stall_at && s < stall_at + 10);
         for (int i = 0; i < NB; i++) data_in[i*WB +: WB] = pat(wcount, i);
         #1;
         if (s == sync_at) ovr_before = sync_overrun;
         if (s >= stall_at && s < stall_at + 10) begin
            st_sclk += int'(driver_sclk);
            st_gclk += int'(driver_gclk);
            st_ready += int'(data_ready);
         end
         n_sclk += int'(driver_sclk);
         if (driver_lat) lat_run++;
         else begin
            if (lat_run == 1) n_wrtgs++;
            else if (lat_run == 3) n_latgs++;
            else if (lat_run != 0) lat_odd++;
            lat_run = 0;
         end
         if (s == 0 && mux_sel !== '0) mux_bad++;
         if (column_ready) begin
            n_col++;
            if (!slice_done && mux_sel !== MUXW'(n_col)) mux_bad++;
         end
         if (slice_done) begin n_done++; done_at = s; end
         if (capk > 0 && capk <= WB) begin
            for (int i = 0; i < NB; i++) w3[i] = {w3[i][WB-2:0], drivers_sin[i]};
            capk++;
         end
         if (data_ready) begin
            if (wcount == 3) capk = 1;
            wcount++;
            n_ready++;
         end
      end
      position_sync = 1'b0;
      conf_load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clk_enable = 1'b1; position_sync = 1'b0; conf_load = 1'b0;
      conf_data = NCONF; data_valid = 1'b0; data_in = '0;
      first_ready = -1; gate_bad = 0; gate_sclk = 0;

      // Reset and boot
      repeat (3) cyc();
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      rst = 1'b0;
      seq_run();
      check("boot_lat", 64'(seq_lat_bad), 64'd0);
      check("boot_sclk", 64'(seq_sclk_bad), 64'd0);
      check("boot_gclk", 64'(seq_gclk_bad), 64'd0);
      check("boot_lanes", 64'(seq_lane_bad), 64'd0);
      check("boot_conf_word", 64'(seq_word), 64'(DCONF));

      // GCLK idles out after GCLK_IDLE_MAX ticks in WAIT_SLICE
      for (int t = 76; t <= 582; t++) begin
         cyc();
         #1;
         if (t == 581) check("idle_gclk_last_on", 64'(driver_gclk), 64'd1);
         if (t == 582) check("idle_gclk_off", 64'(driver_gclk), 64'd0);
      end

      // Full slice, no stalls
      slice_run(6848, -100, -1, -1);
      check("s1_ready", 64'(n_ready), 64'd128);
      check("s1_wrtgs", 64'(n_wrtgs), 64'd120);
      check("s1_latgs", 64'(n_latgs), 64'd8);
      check("s1_lat_odd", 64'(lat_odd), 64'd0);
      check("s1_sclk", 64'(n_sclk), 64'd6144);
      check("s1_column_ready", 64'(n_col), 64'd8);
      check("s1_slice_done", 64'(n_done), 64'd1);
      check("s1_done_at", 64'(done_at), 64'd6848);
      check("s1_mux_step", 64'(mux_bad), 64'd0);
      check("s1_mux_final", 64'(mux_sel), 64'd7);
      check("s1_underrun", 64'(underrun), 64'd0);
      check("s1_word3_lane0", 64'(w3[0]), 64'(pat(3, 0)));

      // Stall before word 3
      slice_run(6858, 219, -1, -1);
      check("s2_stall_sclk", 64'(st_sclk), 64'd0);
      check("s2_stall_gclk", 64'(st_gclk), 64'd10);
      check("s2_stall_ready", 64'(st_ready), 64'd0);
      check("s2_underrun", 64'(underrun), 64'd1);
      check("s2_ready", 64'(n_ready), 64'd128);
      check("s2_done_at", 64'(done_at), 64'd6858);
      check("s2_mux_step", 64'(mux_bad), 64'd0);
      for (int i = 0; i < NB; i++) check($sformatf("s2_word3_lane%0d", i), 64'(w3[i]), 64'(pat(3, i)));

      // conf_load and position_sync mid-slice
      slice_run(6848, -100, 500, 600);
      check("s3_ovr_before", 64'(ovr_before), 64'd0);
      check("s3_sync_overrun", 64'(sync_overrun), 64'd1);
      check("s3_ready", 64'(n_ready), 64'd128);
      check("s3_sclk", 64'(n_sclk), 64'd6144);
      check("s3_latgs", 64'(n_latgs), 64'd8);
      check("s3_done_at", 64'(done_at), 64'd6848);

      // Next sync applies the deferred configuration
      cyc();
      position_sync = 1'b1;
      #1;
      seq_run();
      check("reload_lat", 64'(seq_lat_bad), 64'd0);
      check("reload_sclk", 64'(seq_sclk_bad), 64'd0);
      check("reload_lanes", 64'(seq_lane_bad), 64'd0);
      check("reload_conf_word", 64'(seq_word), 64'(NCONF));

      // Tick gating with clk_enable toggling
      cyc();
      position_sync = 1'b1;
      data_valid = 1'b1;
      #1;
      for (int c = 0; c <= 400; c++) begin
         cyc();
         position_sync = 1'b0;
         clk_enable = (c % 2 == 0);
         #1;
         if (!clk_enable && (driver_sclk || driver_gclk || data_ready)) gate_bad++;
         if (data_ready && first_ready < 0) first_ready = c;
         if (driver_sclk && c <= 240) gate_sclk++;
      end
      clk_enable = 1'b1;
      check("gate_disabled_clocks", 64'(gate_bad), 64'd0);
      check("gate_first_ready", 64'(first_ready), 64'd144);
      check("gate_sclk_word0", 64'(gate_sclk), 64'd48);
      check("pre_reset_underrun", 64'(underrun), 64'd1);
      check("pre_reset_overrun", 64'(sync_overrun), 64'd1);

      // Reset mid-SHIFT
      cyc();
      rst = 1'b1;
      cyc();
      #1;
      check("midreset_outputs", all_outs(), 64'd0);
      rst = 1'b0;
      seq_run();
      check("reboot_lat", 64'(seq_lat_bad), 64'd0);
      check("reboot_sclk", 64'(seq_sclk_bad), 64'd0);
      check("reboot_conf_word", 64'(seq_word), 64'(DCONF));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
